// File: rtl/mux_tree32_pkg.sv
// rtl/mux_tree32_pkg.sv - shared constants for the 32:1 registered mux tree
// LATENCY follows MUX_TREE32_PIPE_EN.
package mux_tree32_pkg;

  localparam int N_LEAVES = 32;
  localparam int SEL_W    = 5;
  localparam int N_LEVELS = 5;
  localparam int N_NODES  = N_LEAVES - 1;

`ifdef MUX_TREE32_PIPE_EN
  localparam int LATENCY = N_LEVELS;
`else
  localparam int LATENCY = 1;
`endif

  // Nodes are numbered level by level, so level l starts at this flat index.
  function automatic int level_base(input int lvl);
    return N_LEAVES - (N_LEAVES >> lvl);
  endfunction

endpackage

// File: rtl/mux_tree32_if.sv
// rtl/mux_tree32_if.sv - sample/result bundle of the 32:1 mux tree
// The master drives leaves, select and valid; the slave returns the result.
interface mux_tree32_if
  import mux_tree32_pkg::*;
#(
  parameter int DATA_W = 1
) ();

  logic [N_LEAVES*DATA_W-1:0] in;
  logic [SEL_W-1:0]           s;
  logic                       in_valid;
  logic [DATA_W-1:0]          out;
  logic                       out_valid;

  modport master (
    output in, s, in_valid,
    input  out, out_valid
  );

  modport slave (
    input  in, s, in_valid,
    output out, out_valid
  );

endinterface

// File: rtl/mux_tree32_node.sv
// rtl/mux_tree32_node.sv - one DATA_W-wide 2:1 tree node
// y takes b when sel is 1 and a when sel is 0.
module mux_tree32_node #(
  parameter int DATA_W = 1
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sel,
  output logic [DATA_W-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux_tree32.sv
// rtl/mux_tree32.sv - 32:1 binary mux tree of 31 nodes, output registered
// MUX_TREE32_PIPE_EN adds a register after every level (latency 5 instead of 1).
module mux_tree32
  import mux_tree32_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic         clk,
  input  logic         rst,
  mux_tree32_if.slave  bus
);

  logic [DATA_W-1:0]   leaf   [N_LEAVES];
  logic [DATA_W-1:0]   node_y [N_NODES];
  logic [DATA_W-1:0]   feed   [N_NODES-1];
  logic [N_LEVELS-1:0] lvl_sel;

  for (genvar i = 0; i < N_LEAVES; i++) begin : g_leaf
    assign leaf[i] = bus.in[i*DATA_W +: DATA_W];
  end

  // Level l pairs entries 2k/2k+1 of the level below; feed is either the
  // raw node outputs or their stage registers depending on the build.
  for (genvar l = 0; l < N_LEVELS; l++) begin : g_lvl
    for (genvar k = 0; k < (N_LEAVES >> (l + 1)); k++) begin : g_node
      localparam int IDX = level_base(l) + k;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;

      if (l == 0) begin : g_from_leaf
        assign a = leaf[2*k];
        assign b = leaf[2*k+1];
      end else begin : g_from_level
        assign a = feed[level_base(l-1) + 2*k];
        assign b = feed[level_base(l-1) + 2*k + 1];
      end

      mux_tree32_node #(.DATA_W(DATA_W)) u_node (
        .a   (a),
        .b   (b),
        .sel (lvl_sel[l]),
        .y   (node_y[IDX])
      );
    end
  end

`ifdef MUX_TREE32_PIPE_EN

  // Select bits ride along with their data. Stage k keeps only the bits
  // still needed, s[4:k+1], LSB first:
  // stage0 [3:0]=s[4:1], stage1 [6:4]=s[4:2], stage2 [8:7]=s[4:3], stage3 [9]=s[4].
  localparam int SEL_PIPE_W = 10;

  logic [DATA_W-1:0]     stage_q [N_NODES];
  logic [SEL_PIPE_W-1:0] sel_pipe;
  logic [LATENCY-1:0]    vld_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_NODES; i++) begin
        stage_q[i] <= '0;
      end
      sel_pipe <= '0;
      vld_pipe <= '0;
    end else begin
      for (int i = 0; i < N_NODES; i++) begin
        stage_q[i] <= node_y[i];
      end
      sel_pipe[3:0] <= bus.s[4:1];
      sel_pipe[6:4] <= sel_pipe[3:1];
      sel_pipe[8:7] <= sel_pipe[6:5];
      sel_pipe[9]   <= sel_pipe[8];
      vld_pipe      <= {vld_pipe[LATENCY-2:0], bus.in_valid};
    end
  end

  assign lvl_sel = {sel_pipe[9], sel_pipe[7], sel_pipe[4], sel_pipe[0], bus.s[0]};

  for (genvar i = 0; i < N_NODES - 1; i++) begin : g_feed
    assign feed[i] = stage_q[i];
  end

  assign bus.out       = stage_q[N_NODES-1];
  assign bus.out_valid = vld_pipe[LATENCY-1];

`else

  logic [DATA_W-1:0] out_q;
  logic              vld_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      out_q <= node_y[N_NODES-1];
      vld_q <= bus.in_valid;
    end
  end

  assign lvl_sel = bus.s;

  for (genvar i = 0; i < N_NODES - 1; i++) begin : g_feed
    assign feed[i] = node_y[i];
  end

  assign bus.out       = out_q;
  assign bus.out_valid = vld_q;

`endif

endmodule

// File: tb/tb_mux_tree32.sv
// tb/tb_mux_tree32.sv - self-checking bench for mux_tree32 (both MUX_TREE32_PIPE_EN builds)
module tb_mux_tree32;

`ifdef MUX_TREE32_PIPE_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst;

  mux_tree32_if #(.DATA_W(1)) bus ();

  mux_tree32 #(.DATA_W(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each result is leaf s of its sample, seen LAT edges later.
  typedef struct packed {
    logic v;
    logic d;
  } res_t;

  res_t hist[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
      for (int i = 0; i < LAT; i++) hist.push_back('0);
    end else begin
      hist.push_back({bus.in_valid, 1'((bus.in >> bus.s) & 32'd1)});
      void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (chk_en && hist.size() > 0) begin
      chk("model_out", 32'(bus.out), 32'(hist[0].d));
      chk("model_valid", 32'(bus.out_valid), 32'(hist[0].v));
    end
  end

  typedef struct {
    logic [31:0] vin;
    logic [4:0]  vs;
    logic        vv;
    logic        eo;
    logic        ev;
  } vec_t;

  vec_t vt[6];

  task automatic drive(input logic [31:0] vin, input logic [4:0] vs, input logic vv);
    bus.in       = vin;
    bus.s        = vs;
    bus.in_valid = vv;
  endtask

  initial begin
    logic [31:0] fixed_in;
    logic [31:0] one;

    vt[0] = '{32'h0000_0001, 5'd0,  1'b1, 1'b1, 1'b1};
    vt[1] = '{32'h0000_0000, 5'd10, 1'b1, 1'b0, 1'b1};
    vt[2] = '{32'h0000_0005, 5'd5,  1'b1, 1'b0, 1'b1};
    vt[3] = '{32'h0000_00E7, 5'd7,  1'b1, 1'b1, 1'b1};
    vt[4] = '{32'h0000_0802, 5'd8,  1'b1, 1'b0, 1'b1};
    vt[5] = '{32'hFFFF_FFFF, 5'd31, 1'b0, 1'b1, 1'b0};

    rst = 1'b0;
    drive(32'h0, 5'd0, 1'b0);
    #1 rst = 1'b1;
    #2;
    chk("reset_out", 32'(bus.out), 32'd0);
    chk("reset_valid", 32'(bus.out_valid), 32'd0);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed vectors, each held for the full latency.
    for (int i = 0; i < 6; i++) begin
      drive(vt[i].vin, vt[i].vs, vt[i].vv);
      repeat (LAT) @(negedge clk);
      chk($sformatf("vec%0d_out", i), 32'(bus.out), 32'(vt[i].eo));
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vt[i].ev));
    end

    // Walking one then walking zero, back to back with no bubbles.
    for (int pass = 0; pass < 2; pass++) begin
      for (int j = 0; j < 32 + LAT; j++) begin
        if (j >= LAT) begin
          chk(pass == 0 ? "walk1_out" : "walk0_out", 32'(bus.out), pass == 0 ? 32'd1 : 32'd0);
          chk("walk_valid", 32'(bus.out_valid), 32'd1);
        end
        if (j < 32) begin
          one = 32'd1 << j;
          drive(pass == 0 ? one : ~one, 5'(j), 1'b1);
        end else begin
          drive(32'h0, 5'd0, 1'b0);
        end
        @(negedge clk);
      end
    end

    // Fixed random leaves, select stepping every cycle.
    fixed_in = $urandom;
    for (int j = 0; j < 32 + LAT; j++) begin
      if (j >= LAT) begin
        chk("sel_step_out", 32'(bus.out), (fixed_in >> (j - LAT)) & 32'd1);
      end
      drive(fixed_in, 5'(j), j < 32);
      @(negedge clk);
    end

    for (int j = 0; j < 300; j++) begin
      drive($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      @(negedge clk);
    end

    // Inputs changed between edges must not reach out before the next edge.
    drive(32'hA5A5_5A5A, 5'd3, 1'b1);
    repeat (LAT) @(negedge clk);
    #2 drive(32'h5A5A_A5A5, 5'd4, 1'b1);
    #1 chk("midcycle_out", 32'(bus.out), 32'(hist[0].d));
    chk("midcycle_held", 32'(bus.out), 32'd1);
    @(negedge clk);

    // Asynchronous reset while a stream of ones is in flight.
    drive(32'hFFFF_FFFF, 5'd17, 1'b1);
    repeat (LAT + 1) @(negedge clk);
    chk("pre_rst_out", 32'(bus.out), 32'd1);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_out", 32'(bus.out), 32'd0);
    chk("rst_async_valid", 32'(bus.out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
    end
    drive(32'hFFFF_FFFF, 5'd9, 1'b1);
    for (int j = 1; j <= LAT; j++) begin
      @(negedge clk);
      chk("first_after_rst_valid", 32'(bus.out_valid), 32'(j == LAT));
    end
    chk("first_after_rst_out", 32'(bus.out), 32'd1);
    drive(32'h0, 5'd0, 1'b0);
    repeat (LAT + 2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_tree32.md
MUX_TREE32 -- requirements
Module: mux_tree32

Interface
REQ-001 Parameter DATA_W, default 1: bit width of each of the 32 leaf inputs and of the output.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in  input  32*DATA_W  leaf data; leaf i occupies bits [i*DATA_W +: DATA_W].
REQ-005 s  input  5  select; unsigned index 0..31 of the leaf to forward.
REQ-006 in_valid  input  1  qualifies in/s for the current cycle.
REQ-007 out  output  DATA_W  selected leaf, registered.
REQ-008 out_valid  output  1  out holds the result of a qualified sample.

Function
REQ-009 The block SHALL implement a binary tree of 31 two-input nodes in 5 levels.
- Level 0 (16 nodes) is steered by s[0] and pairs leaves (2k, 2k+1).
- Level L is steered by s[L]; s[4] drives the root.
REQ-010 Each node SHALL forward its upper input when its select bit is 1 and its lower input when it is 0.
REQ-011 The root result SHALL equal in leaf[s] for every s in 0..31; there is no out-of-range case.
REQ-012 Without the pipeline option, out and out_valid SHALL update on the clock edge after the sample, giving latency 1 cycle.
REQ-013 The block SHALL capture a new sample every cycle, giving throughput 1 per cycle and no backpressure.
REQ-014 out_valid SHALL equal in_valid delayed by exactly the configured latency.
REQ-015 out SHALL update every cycle regardless of in_valid; consumers qualify out with out_valid.
REQ-016 Changing in or s between edges SHALL have no effect on out until the next edge.

Reset
REQ-017 While rst=1, out SHALL be 0, out_valid SHALL be 0, and every internal pipeline register SHALL be 0, all asynchronously.
REQ-018 Deassertion of rst SHALL be sampled on a clock edge.
- The first sample captured after deassertion emerges after the configured latency.
- Samples in flight when rst asserts are discarded, with no partial output.

Configuration
REQ-019 Macro MUX_TREE32_PIPE_EN SHALL control per-level pipelining.
- Defined: a register stage follows each of the 5 levels, so the root stage register drives out; latency is 5 cycles.
- Defined: the unused upper select bits and the valid bit are delayed in step with the data, so each result uses the select sampled with its own data.
- Not defined: the tree is purely combinational and only the output register exists, giving latency 1.
- Throughput is 1 per cycle in both modes.

Structure
REQ-020 Package mux_tree32_pkg SHALL hold:
- constants N_LEAVES=32, SEL_W=5, N_LEVELS=5;
- the latency constant, 5 or 1 depending on MUX_TREE32_PIPE_EN.
REQ-021 Sub-module mux_tree32_node SHALL implement one DATA_W-wide 2:1 node.
- Its ports are a, b, sel, y, with y = sel ? b : a.
- The tree is built from 31 instances.

Verification (DATA_W=1; expected out checked LAT cycles after the sample, LAT=1 or 5)
REQ-022 in=32'h0000_0001, s=0, in_valid=1 -> out=1, out_valid=1.
REQ-023 in=32'h0000_0000, s=10 -> out=0; then in=32'h0000_0005, s=5 -> out=0 (bit 5 clear).
REQ-024 in=32'h0000_00E7, s=7 -> out=1; then in=32'h0000_0802, s=8 -> out=0.
REQ-025 Walking-one sweep:
- in=1<<k with s=k for k=0..31 back-to-back -> out=1 each cycle.
- in=~(1<<k) with s=k -> out=0 each cycle.
- No bubbles between consecutive results.
REQ-026 Reset cases:
- Assert rst mid-stream with in=32'hFFFF_FFFF -> out=0 and out_valid=0 immediately, without waiting for clk.
- After release, in_valid=0 for 3 cycles -> out_valid stays 0.
REQ-027 Pipeline option, MUX_TREE32_PIPE_EN defined:
- Change s every cycle over 0..31 with a fixed random in.
- Each out equals in[s] of the sample taken exactly 5 cycles earlier.
